// File: rtl/clkdiv_seq_pkg.sv
// Package for the CLKDIV start-up / calibration sequencer.
// Holds the FSM state encodings, the synchroniser settle allowance and
// helper functions used to size the counters.
`timescale 1ns/1ps
package clkdiv_seq_pkg;

  // Check-window cycles skipped while the sense synchroniser settles.
  localparam int unsigned SYNC_IGNORE = 4;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHold  = 3'd1;
  localparam logic [2:0] StCheck = 3'd2;
  localparam logic [2:0] StReady = 3'd3;
  localparam logic [2:0] StCalib = 3'd4;
  localparam logic [2:0] StGap   = 3'd5;
  localparam logic [2:0] StFault = 3'd6;

  // Width needed to hold max_val, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-low reset.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, clears both stages
//   d_i    - asynchronous input
//   q_o    - synchronised output (second stage)
`timescale 1ns/1ps
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/clkdiv_seq_ctrl.sv
// Start-up and calibration sequencer for the CLKDIV primitive.
// After PLL lock it holds the divider in reset, releases it, proves the divided
// clock toggles, then serves CALIB pulse requests. Single clock domain (hclkin).
// Ports:
//   hclkin     - fast clock, also the divider input clock
//   resetn     - asynchronous active-low reset
//   pll_lock   - PLL lock (asynchronous, synchronised here)
//   div_sense  - divided clock fed back (asynchronous, synchronised here)
//   calib_req  - level request; rising edge while ready starts one calib pulse
//   div_resetn - to CLKDIV RESETN
//   div_calib  - to CLKDIV CALIB
//   div_ready  - divided clock verified and usable
//   calib_busy - calib pulse or post-pulse gap in progress
//   fault      - divider failed every allowed check
`timescale 1ns/1ps
module clkdiv_seq_ctrl #(
  parameter int unsigned HOLD_CYC  = 16,
  parameter int unsigned CHECK_WIN = 64,
  parameter int unsigned MIN_EDGES = 12,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned CALIB_W   = 2,
  parameter int unsigned CALIB_GAP = 8
) (
  input  logic hclkin,
  input  logic resetn,
  input  logic pll_lock,
  input  logic div_sense,
  input  logic calib_req,
  output logic div_resetn,
  output logic div_calib,
  output logic div_ready,
  output logic calib_busy,
  output logic fault
);
  import clkdiv_seq_pkg::*;

  localparam int unsigned CntW   = cnt_w(max4(HOLD_CYC, CHECK_WIN, CALIB_W, CALIB_GAP));
  localparam int unsigned EdgeW  = cnt_w(MIN_EDGES);
  localparam int unsigned RetryW = cnt_w(MAX_RETRY);

  logic              lock_s;
  logic              sense_s;
  logic              sense_q;
  logic              req_q;
  logic              req_q2;
  logic              sense_rise;
  logic              req_rise;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [EdgeW-1:0]  edge_q, edge_d, edge_next;
  logic [RetryW-1:0] retry_q, retry_d;

  sync2 u_sync_lock (
    .clk_i  (hclkin),
    .rst_ni (resetn),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  sync2 u_sync_sense (
    .clk_i  (hclkin),
    .rst_ni (resetn),
    .d_i    (div_sense),
    .q_o    (sense_s)
  );

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      sense_q <= 1'b0;
      req_q   <= 1'b0;
      req_q2  <= 1'b0;
    end else begin
      sense_q <= sense_s;
      req_q   <= calib_req;
      req_q2  <= req_q;
    end
  end

  assign sense_rise = sense_s & ~sense_q;
  assign req_rise   = req_q & ~req_q2;

  // Saturating edge count; edges during the synchroniser settle cycles are ignored.
  always_comb begin
    edge_next = edge_q;
    if (state_q == StCheck && cnt_q >= CntW'(SYNC_IGNORE) && sense_rise && edge_q != '1) begin
      edge_next = edge_q + EdgeW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    retry_d = retry_q;
    case (state_q)
      StIdle: begin
        cnt_d   = '0;
        edge_d  = '0;
        retry_d = '0;
        if (lock_s) state_d = StHold;
      end
      StHold: begin
        if (cnt_q == CntW'(HOLD_CYC - 1)) begin
          cnt_d   = '0;
          edge_d  = '0;
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCheck: begin
        edge_d = edge_next;
        if (cnt_q == CntW'(CHECK_WIN - 1)) begin
          cnt_d  = '0;
          edge_d = '0;
          if (edge_next >= EdgeW'(MIN_EDGES)) begin
            state_d = StReady;
          end else if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StHold;
          end else begin
            state_d = StFault;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StReady: begin
        cnt_d = '0;
        if (req_rise && !calib_busy) state_d = StCalib;
      end
      StCalib: begin
        if (cnt_q == CntW'(CALIB_W - 1)) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(CALIB_GAP - 1)) begin
          cnt_d   = '0;
          state_d = StReady;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFault: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Lock loss overrides every other transition.
    if (!lock_s && state_q != StIdle) begin
      state_d = StIdle;
      cnt_d   = '0;
      edge_d  = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      edge_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      retry_q <= retry_d;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      div_resetn <= 1'b0;
      div_calib  <= 1'b0;
      div_ready  <= 1'b0;
      calib_busy <= 1'b0;
      fault      <= 1'b0;
    end else begin
      div_resetn <= state_d inside {StCheck, StReady, StCalib, StGap};
      div_calib  <= (state_d == StCalib);
      div_ready  <= state_d inside {StReady, StCalib, StGap};
      calib_busy <= state_d inside {StCalib, StGap};
      fault      <= (state_d == StFault);
    end
  end

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
`timescale 1ns/1ps
module tb_clkdiv_seq_ctrl;

  logic hclkin = 1'b0;
  logic resetn;
  logic pll_lock;
  logic div_sense;
  logic calib_req;
  logic div_resetn;
  logic div_calib;
  logic div_ready;
  logic calib_busy;
  logic fault;

  logic sense_run;
  logic sense_man;
  logic [4:0] outs;

  int total = 0;
  int bad   = 0;
  int n;
  int rises;
  logic prev;
  logic seen;

  clkdiv_seq_ctrl dut (
    .hclkin     (hclkin),
    .resetn     (resetn),
    .pll_lock   (pll_lock),
    .div_sense  (div_sense),
    .calib_req  (calib_req),
    .div_resetn (div_resetn),
    .div_calib  (div_calib),
    .div_ready  (div_ready),
    .calib_busy (calib_busy),
    .fault      (fault)
  );

  always #5 hclkin = ~hclkin;

  // Divide-by-3.5 stand-in: 7-cycle pattern with two rising edges, or a manual level.
  int unsigned sense_ph = 0;
  always @(negedge hclkin) begin
    sense_ph = (sense_ph == 6) ? 0 : sense_ph + 1;
    div_sense = sense_run ? (sense_ph inside {0, 1, 4, 5}) : sense_man;
  end

  assign outs = {div_resetn, div_calib, div_ready, calib_busy, fault};

  task automatic step(input int k = 1);
    repeat (k) @(posedge hclkin);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] exp);
    total++;
    assert (outs === exp) else begin
      bad++;
      $error("FAIL %s observed(rstn,cal,rdy,busy,flt)=%b expected=%b", tag, outs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Steps until the selected output is 1 or the budget runs out; k = steps taken.
  task automatic wait_sig(input int sel, input int budget, output int k);
    logic v;
    k = 0;
    v = (sel == 0) ? div_resetn : (sel == 1) ? div_ready : fault;
    while (v !== 1'b1 && k < budget) begin
      step();
      k++;
      v = (sel == 0) ? div_resetn : (sel == 1) ? div_ready : fault;
    end
  endtask

  task automatic pulses(input int k);
    repeat (k) begin
      sense_man = 1'b1;
      step(2);
      sense_man = 1'b0;
      step(2);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    pll_lock  = 1'b0;
    calib_req = 1'b0;
    sense_run = 1'b0;
    sense_man = 1'b0;
    step(3);
    check_outs("reset", 5'b00000);
    resetn = 1'b1;
    step(2);
    check_outs("idle", 5'b00000);

    // Lock with a toggling divider: release at +19, ready 64 cycles later.
    sense_run = 1'b1;
    pll_lock  = 1'b1;
    step(18);
    check_bit("t1_rstn_pre", div_resetn, 1'b0);
    step(1);
    check_outs("t1_rstn_rise", 5'b10000);
    step(63);
    check_bit("t1_ready_pre", div_ready, 1'b0);
    step(1);
    check_outs("t1_ready", 5'b10100);

    // Calib pulse: 2 cycles calib, 10 cycles busy, second edge during busy dropped.
    calib_req = 1'b1;
    step(1);
    check_bit("t3_lat1", div_calib, 1'b0);
    step(1);
    check_outs("t3_calib1", 5'b11110);
    step(1);
    check_outs("t3_calib2", 5'b11110);
    step(1);
    check_outs("t3_gap", 5'b10110);
    calib_req = 1'b0;
    step(1);
    calib_req = 1'b1;
    step(6);
    check_bit("t3_busy_last", calib_busy, 1'b1);
    step(1);
    check_outs("t3_done", 5'b10100);
    seen = 1'b0;
    repeat (6) begin
      step(1);
      seen = seen | div_calib;
    end
    check_bit("t3_dropped_req", seen, 1'b0);

    // Lock loss mid-CALIB, then clean re-sequence.
    calib_req = 1'b0;
    step(2);
    calib_req = 1'b1;
    step(2);
    check_bit("t4_in_calib", div_calib, 1'b1);
    pll_lock = 1'b0;
    step(2);
    check_bit("t4_busy_pre", calib_busy, 1'b1);
    step(1);
    check_outs("t4_calib_drop", 5'b00000);
    calib_req = 1'b0;
    step(2);
    pll_lock = 1'b1;
    step(18);
    check_bit("t4_reseq_pre", div_resetn, 1'b0);
    step(1);
    check_bit("t4_reseq_rstn", div_resetn, 1'b1);
    step(64);
    check_outs("t4_reseq_ready", 5'b10100);

    // Stuck sense: four attempts, fault at lock+3+4*80.
    sense_run = 1'b0;
    sense_man = 1'b0;
    pll_lock  = 1'b0;
    step(4);
    pll_lock = 1'b1;
    n = 0;
    rises = 0;
    prev = div_resetn;
    while (fault !== 1'b1 && n < 400) begin
      step();
      n++;
      if (div_resetn && !prev) rises++;
      prev = div_resetn;
    end
    check_int("t2_fault_cycle", n, 323);
    check_int("t2_attempts", rises, 4);
    check_outs("t2_fault", 5'b00001);
    pll_lock = 1'b0;
    step(3);
    check_outs("t2_clear", 5'b00000);
    step(2);

    // Lock loss mid-CHECK on the last attempt must clear retry.
    pll_lock = 1'b1;
    step(270);
    check_outs("t4_in_check", 5'b10000);
    pll_lock = 1'b0;
    step(2);
    check_bit("t4_check_pre", div_resetn, 1'b1);
    step(1);
    check_outs("t4_check_drop", 5'b00000);
    step(2);
    pll_lock = 1'b1;
    wait_sig(2, 400, n);
    check_int("t4_retry_cleared", n, 323);
    pll_lock = 1'b0;
    step(4);

    // Asynchronous reset mid-HOLD and mid-READY.
    sense_run = 1'b1;
    pll_lock  = 1'b1;
    step(10);
    #2 resetn = 1'b0;
    #1 check_outs("t5_hold_async", 5'b00000);
    step(1);
    resetn = 1'b1;
    step(18);
    check_bit("t5_restart_pre", div_resetn, 1'b0);
    step(1);
    check_bit("t5_restart", div_resetn, 1'b1);
    step(64);
    check_bit("t5_ready", div_ready, 1'b1);
    #2 resetn = 1'b0;
    #1 check_outs("t5_ready_async", 5'b00000);
    step(1);
    resetn    = 1'b1;
    pll_lock  = 1'b0;
    sense_run = 1'b0;
    sense_man = 1'b0;
    step(3);

    // 11 edges -> retry, 12 edges -> ready.
    pll_lock = 1'b1;
    wait_sig(0, 40, n);
    check_int("t6_rstn_lat", n, 19);
    step(10);
    pulses(11);
    step(9);
    check_bit("t6_11_inwin", div_resetn, 1'b1);
    step(1);
    check_outs("t6_11_retry", 5'b00000);
    step(15);
    check_bit("t6_hold_pre", div_resetn, 1'b0);
    step(1);
    check_bit("t6_hold_done", div_resetn, 1'b1);
    step(10);
    pulses(12);
    step(5);
    check_bit("t6_12_inwin", div_ready, 1'b0);
    step(1);
    check_outs("t6_12_ready", 5'b10100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
